sha2_core: RTL and testbench
============================

Name: sha2_core

Overview:
- Unified, parametrised SHA-2 compression engine. Successor to the fixed 64-bit SHA-512-family core.
- Covers SHA-224/256 (WORD=32) and SHA-384/512/512-224/512-256 (WORD=64) with configurable rounds per cycle.
- Adds valid/ready handshakes on input and output, multi-block chaining via a first-block flag, and on-the-fly 16-word message schedule instead of a full W array.
- Sits between the padding/block-formatter and the hash result consumer.

Parameters:
WORD, 64, word width in bits; legal values 32 or 64. ROUNDS = 64 for WORD=32, 80 for WORD=64 (derived localparam).
UNROLL, 1, rounds computed per clock; legal values 1, 2, 4 (divides ROUNDS).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
in_valid  in  1  block available
in_ready  out  1  core can accept block
in_data  in  16*WORD  message block; word i = in_data[i*WORD +: WORD], word 0 first in schedule
in_first  in  1  block is first of message; load IV selected by in_mode
in_mode  in  2  WORD=64: 0=512/224, 1=512/256, 2=384, 3=512; WORD=32: 0=224, 1..3=256
out_valid  out  1  hash result valid
out_ready  in  1  consumer accepts result
out_hash  out  8*WORD  {a,b,c,d,e,f,g,h}, a in MSBs, truncated bits forced to 0
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, RUN, DONE. Reset (rst==0 at posedge): state=IDLE, round counter=0, a..h=0, chaining H=0, latched mode=3 (WORD=64) / 1 (WORD=32). Outputs after reset: in_ready=1, out_valid=0, out_hash=0, busy=0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
- On accept:
  - If in_first=1: H <= IV[in_mode] and mode latched from in_mode.
  - If in_first=0: H <= previous untruncated final state and in_mode is ignored.
  - a..h <= selected H; schedule window Wn[0..15] <= in_data words; counter <= 0; state <= RUN.
- RUN, each cycle, applies UNROLL sequential rounds t..t+UNROLL-1 combinationally. Per round:
  - Use Wn[0] and K[t].
  - Shift window down one word; append σ1(Wn[14]) + Wn[9] + σ0(Wn[1]) + Wn[0].
  - T1, T2, Σ, σ, Ch and Maj are per FIPS 180-4 for the WORD size (32-bit rotations 2/13/22, 6/11/25, 7/18/>>3, 17/19/>>10; 64-bit 28/34/39, 14/18/41, 1/8/>>7, 19/61/>>6).
  - All additions modulo 2^WORD.
- Counter advances by UNROLL each RUN cycle. On the cycle processing the last rounds:
  - a..h <= new a..h + H (feed-forward); H <= same sum.
  - state <= DONE.
- Latency: out_valid rises exactly ROUNDS/UNROLL cycles after the accepting edge (80 for WORD=64, UNROLL=1).
- DONE:
  - out_valid=1; out_hash stable until out_ready=1.
  - With out_ready=1 and no new accept, state <= IDLE.
  - With out_ready=1 and simultaneous accept, go directly to RUN (back-to-back, no bubble). A non-first block chains off the hash just delivered.
- Truncation on out_hash (internal H untouched):
  - 224 (WORD=32): low 32 bits zero.
  - 384: low 128 zero.
  - 512/256: low 256 zero.
  - 512/224: low 288 zero.
- in_first=0 with no prior first block after reset: chains from H=0 (defined, not an error).
- in_valid during RUN: ignored; in_ready=0; block must be held by source.
- Reset mid-RUN or in DONE: abort immediately to reset state; partial result discarded; out_valid=0 next cycle.
- K tables: 64x32 or 80x64 constants, selected by WORD. IV tables: 4 per WORD size, constant.

Test Plan:
- WORD=32, UNROLL=1, mode=1, first=1, "abc" block (word0=32'h61626380, word15=32'h18, rest 0) -> out_valid 64 cycles after accept; out_hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Same block, mode=0 -> out_hash=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7 followed by 32 zero bits.
- WORD=64, UNROLL=4, mode=3, "abc" (word0=64'h6162638000000000, word15=64'h18) -> out_valid 20 cycles after accept; out_hash=ddaf35a193617abacc417349ae2041311 2e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f (no space). Repeat with mode=2 -> cb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7 plus 128 zero bits.
- WORD=32, two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first=1 then first=0, second block presented while DONE with out_ready=1) -> second block accepted on same edge result is consumed; final out_hash=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_hash stable, in_ready=0, busy=1; raise out_ready -> out_valid drops next cycle, in_ready=1.
- Assert rst=0 at round 30 of a block, then rerun "abc" SHA-256 with first=1 -> out_valid=0 the cycle after reset; fresh run produces the correct digest (no leakage of aborted state).

Source files
------------

// File: rtl/sha2_core_if.sv
// rtl/sha2_core_if.sv - block-in / digest-out handshake bundle for sha2_core
interface sha2_core_if #(
    parameter int WORD = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [16*WORD-1:0]    in_data;
    logic                  in_first;
    logic [1:0]            in_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*WORD-1:0]     out_hash;

    modport master (
        output in_valid, in_data, in_first, in_mode, out_ready,
        input  in_ready, out_valid, out_hash
    );

    modport slave (
        input  in_valid, in_data, in_first, in_mode, out_ready,
        output in_ready, out_valid, out_hash
    );
endinterface

// File: rtl/sha2_core.sv
// rtl/sha2_core.sv - parametrised SHA-2 compression engine with rolling 16-word schedule
module sha2_core #(
    parameter int WORD   = 64,
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst,
    sha2_core_if.slave  bus,
    output logic        busy
);
    localparam int ROUNDS = (WORD == 64) ? 80 : 64;
    localparam logic [6:0] LAST_CNT = 7'(ROUNDS - UNROLL);
    localparam logic [1:0] MODE_RST = (WORD == 64) ? 2'd3 : 2'd1;

    typedef logic [WORD-1:0]    word_t;
    typedef logic [8*WORD-1:0]  hash_t;
    typedef logic [16*WORD-1:0] blk_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // SHA-256 round constants are the top 32 bits of the SHA-512 ones, so one table serves both
    localparam logic [63:0] K64 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // Indexed by in_mode: 512/224, 512/256, 384, 512
    localparam logic [511:0] IV64 [4] = '{
        512'h8c3d37c819544da273e1996689dcd4d61dfab7ae32ff9c82679dd514582f9fcf0f6d2b697bd44da877e36f7304c489423f9d85a86a1d36c81112e6ad91d692a1,
        512'h22312194fc2bf72c9f555fa3c84c64c22393b86b6f53b151963877195940eabd96283ee2a88effe3be5e1e25538639922b0199fc2c85b8aa0eb72ddc81c52ca2,
        512'hcbbb9d5dc1059ed8629a292a367cd5079159015a3070dd17152fecd8f70e593967332667ffc00b318eb44a8768581511db0c2e0d64f98fa747b5481dbefa4fa4,
        512'h6a09e667f3bcc908bb67ae8584caa73b3c6ef372fe94f82ba54ff53a5f1d36f1510e527fade682d19b05688c2b3e6c1f1f83d9abfb41bd6b5be0cd19137e2179
    };

    // Indexed by in_mode: 224, then 256 for the remaining codes
    localparam logic [255:0] IV32 [4] = '{
        256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4,
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (WORD - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        if (WORD == 32) return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
        return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
    endfunction

    function automatic word_t bsig1(input word_t x);
        if (WORD == 32) return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
        return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
    endfunction

    function automatic word_t ssig0(input word_t x);
        if (WORD == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
        return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    endfunction

    function automatic word_t ssig1(input word_t x);
        if (WORD == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
        return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

    // Out-of-range indices only occur while idle, when the round result is discarded
    function automatic word_t k_of(input logic [6:0] t);
        if (t < 7'd80) return word_t'(K64[t] >> (64 - WORD));
        return '0;
    endfunction

    function automatic hash_t iv_of(input logic [1:0] m);
        if (WORD == 64) return hash_t'(IV64[m]);
        return hash_t'(IV32[m]);
    endfunction

    state_t     state_q, state_d;
    hash_t      st_q;
    hash_t      h_q;
    blk_t       w_q;
    logic [6:0] cnt_q;
    logic [1:0] mode_q;

    logic       accept;
    logic       last_rnd;
    hash_t      start_h;
    hash_t      rnd_st;
    hash_t      ff_sum;
    blk_t       rnd_w;
    hash_t      out_mask;
    int         nz;

    word_t      ra, rb, rc, rd, re, rf, rg, rh;
    word_t      t1, t2, wnew;
    blk_t       wv;

    assign accept   = bus.in_valid & bus.in_ready;
    assign last_rnd = (cnt_q == LAST_CNT);
    assign start_h  = bus.in_first ? iv_of(bus.in_mode) : h_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: DONE may hand straight over to RUN when a block arrives as the result leaves
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.in_valid) state_d = S_RUN;
            S_RUN:  if (last_rnd)     state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = bus.in_valid ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready);
        bus.out_valid = (state_q == S_DONE);
        busy          = (state_q != S_IDLE);
    end

    // UNROLL chained rounds per cycle, rolling the 16-word schedule window as we go
    always_comb begin
        ra = st_q[7*WORD +: WORD];
        rb = st_q[6*WORD +: WORD];
        rc = st_q[5*WORD +: WORD];
        rd = st_q[4*WORD +: WORD];
        re = st_q[3*WORD +: WORD];
        rf = st_q[2*WORD +: WORD];
        rg = st_q[1*WORD +: WORD];
        rh = st_q[0 +: WORD];
        wv = w_q;
        t1 = '0;
        t2 = '0;
        wnew = '0;
        for (int u = 0; u < UNROLL; u++) begin
            wnew = ssig1(wv[14*WORD +: WORD]) + wv[9*WORD +: WORD]
                 + ssig0(wv[1*WORD +: WORD]) + wv[0 +: WORD];
            t1 = rh + bsig1(re) + ((re & rf) ^ (~re & rg))
               + k_of(cnt_q + 7'(u)) + wv[0 +: WORD];
            t2 = bsig0(ra) + ((ra & rb) ^ (ra & rc) ^ (rb & rc));
            rh = rg;
            rg = rf;
            rf = re;
            re = rd + t1;
            rd = rc;
            rc = rb;
            rb = ra;
            ra = t1 + t2;
            wv = {wnew, wv[16*WORD-1:WORD]};
        end
        rnd_st = {ra, rb, rc, rd, re, rf, rg, rh};
        rnd_w  = wv;
    end

    // Feed-forward of the chaining value, word by word
    always_comb begin
        ff_sum = '0;
        for (int i = 0; i < 8; i++) begin
            ff_sum[i*WORD +: WORD] = rnd_st[i*WORD +: WORD] + h_q[i*WORD +: WORD];
        end
    end

    // Truncated variants zero the tail of the digest; internal chaining keeps all bits
    always_comb begin
        nz = 0;
        if (WORD == 32) begin
            if (mode_q == 2'd0) nz = 32;
        end else begin
            case (mode_q)
                2'd0:    nz = 288;
                2'd1:    nz = 256;
                2'd2:    nz = 128;
                default: nz = 0;
            endcase
        end
        out_mask = {(8*WORD){1'b1}} << nz;
    end

    assign bus.out_hash = st_q & out_mask;

    // Working state, chaining value, schedule window, round counter and latched mode
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q   <= '0;
            h_q    <= '0;
            w_q    <= '0;
            cnt_q  <= '0;
            mode_q <= MODE_RST;
        end else if (accept) begin
            st_q  <= start_h;
            h_q   <= start_h;
            w_q   <= bus.in_data;
            cnt_q <= '0;
            if (bus.in_first) mode_q <= bus.in_mode;
        end else if (state_q == S_RUN) begin
            w_q   <= rnd_w;
            cnt_q <= cnt_q + 7'(UNROLL);
            if (last_rnd) begin
                st_q <= ff_sum;
                h_q  <= ff_sum;
            end else begin
                st_q <= rnd_st;
            end
        end
    end
endmodule

// File: tb/tb_sha2_core.sv
// tb/tb_sha2_core.sv - directed known-answer bench for sha2_core (32-bit and 64-bit builds)
module tb_sha2_core;
    logic clk = 1'b0;
    logic rst;
    logic busy32, busy64;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat;

    always #5 clk = ~clk;

    sha2_core_if #(.WORD(32)) b32 ();
    sha2_core_if #(.WORD(64)) b64 ();

    sha2_core #(.WORD(32), .UNROLL(1)) u_dut32 (.clk(clk), .rst(rst), .bus(b32.slave), .busy(busy32));
    sha2_core #(.WORD(64), .UNROLL(4)) u_dut64 (.clk(clk), .rst(rst), .bus(b64.slave), .busy(busy64));

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch32(input logic [511:0] blk, input logic first, input logic [1:0] mode);
        @(negedge clk);
        b32.in_data  = blk;
        b32.in_first = first;
        b32.in_mode  = mode;
        b32.in_valid = 1'b1;
        chk("in_ready32_at_accept", 512'(b32.in_ready), 512'd1);
        @(posedge clk);
        #1;
        b32.in_valid = 1'b0;
    endtask

    task automatic launch64(input logic [1023:0] blk, input logic first, input logic [1:0] mode);
        @(negedge clk);
        b64.in_data  = blk;
        b64.in_first = first;
        b64.in_mode  = mode;
        b64.in_valid = 1'b1;
        chk("in_ready64_at_accept", 512'(b64.in_ready), 512'd1);
        @(posedge clk);
        #1;
        b64.in_valid = 1'b0;
    endtask

    task automatic wait32(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (b32.out_valid !== 1'b1 && n < 300);
    endtask

    task automatic wait64(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (b64.out_valid !== 1'b1 && n < 300);
    endtask

    task automatic consume32;
        b32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b32.out_ready = 1'b0;
    endtask

    task automatic consume64;
        b64.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b64.out_ready = 1'b0;
    endtask

    localparam logic [255:0] EXP_ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EXP_ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
    localparam logic [255:0] EXP_TWO256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] EXP_ABC512 = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
    localparam logic [511:0] EXP_ABC384 = 512'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a700000000000000000000000000000000;
    localparam logic [31:0]  MSG2 [14] = '{
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
        32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071
    };

    logic [511:0]  abc32, blk1, blk2;
    logic [1023:0] abc64;

    initial begin
        abc32 = '0;
        abc32[0 +: 32]     = 32'h61626380;
        abc32[15*32 +: 32] = 32'h18;
        abc64 = '0;
        abc64[0 +: 64]     = 64'h6162638000000000;
        abc64[15*64 +: 64] = 64'h18;
        blk1 = '0;
        for (int i = 0; i < 14; i++) blk1[i*32 +: 32] = MSG2[i];
        blk1[14*32 +: 32] = 32'h80000000;
        blk2 = '0;
        blk2[15*32 +: 32] = 32'h000001c0;

        rst = 1'b0;
        b32.in_valid = 1'b0; b32.in_data = '0; b32.in_first = 1'b0; b32.in_mode = 2'd0; b32.out_ready = 1'b0;
        b64.in_valid = 1'b0; b64.in_data = '0; b64.in_first = 1'b0; b64.in_mode = 2'd0; b64.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready32", 512'(b32.in_ready), 512'd1);
        chk("rst_out_valid32", 512'(b32.out_valid), 512'd0);
        chk("rst_out_hash32", 512'(b32.out_hash), 512'd0);
        chk("rst_busy32", 512'(busy32), 512'd0);
        chk("rst_out_hash64", b64.out_hash, 512'd0);
        chk("rst_busy64", 512'(busy64), 512'd0);
        rst = 1'b1;

        // SHA-256 "abc", then hold the result under backpressure
        launch32(abc32, 1'b1, 2'd1);
        chk("run_busy32", 512'(busy32), 512'd1);
        wait32(lat);
        chk("lat_abc256", 512'(lat), 512'd64);
        chk("hash_abc256", 512'(b32.out_hash), 512'(EXP_ABC256));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hash", 512'(b32.out_hash), 512'(EXP_ABC256));
            chk("bp_in_ready", 512'(b32.in_ready), 512'd0);
            chk("bp_busy", 512'(busy32), 512'd1);
            chk("bp_out_valid", 512'(b32.out_valid), 512'd1);
        end
        b32.out_ready = 1'b1;
        #2;
        chk("bp_release_in_ready", 512'(b32.in_ready), 512'd1);
        @(posedge clk);
        #1;
        b32.out_ready = 1'b0;
        chk("post_out_valid", 512'(b32.out_valid), 512'd0);
        chk("post_in_ready", 512'(b32.in_ready), 512'd1);
        chk("post_busy", 512'(busy32), 512'd0);

        // SHA-224 "abc"
        launch32(abc32, 1'b1, 2'd0);
        wait32(lat);
        chk("lat_abc224", 512'(lat), 512'd64);
        chk("hash_abc224", 512'(b32.out_hash), 512'(EXP_ABC224));
        consume32();

        // SHA-512 and SHA-384 "abc" on the 4-rounds-per-cycle build
        launch64(abc64, 1'b1, 2'd3);
        wait64(lat);
        chk("lat_abc512", 512'(lat), 512'd20);
        chk("hash_abc512", b64.out_hash, EXP_ABC512);
        consume64();
        launch64(abc64, 1'b1, 2'd2);
        wait64(lat);
        chk("lat_abc384", 512'(lat), 512'd20);
        chk("hash_abc384", b64.out_hash, EXP_ABC384);
        consume64();

        // Two-block message; second block rides in on the edge that consumes the first result
        launch32(blk1, 1'b1, 2'd1);
        wait32(lat);
        chk("lat_blk1", 512'(lat), 512'd64);
        b32.in_data   = blk2;
        b32.in_first  = 1'b0;
        b32.in_mode   = 2'd0;
        b32.in_valid  = 1'b1;
        b32.out_ready = 1'b1;
        #2;
        chk("b2b_in_ready", 512'(b32.in_ready), 512'd1);
        @(posedge clk);
        #1;
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b0;
        chk("b2b_out_valid", 512'(b32.out_valid), 512'd0);
        chk("b2b_busy", 512'(busy32), 512'd1);
        wait32(lat);
        chk("lat_blk2", 512'(lat), 512'd64);
        chk("hash_two_block", 512'(b32.out_hash), 512'(EXP_TWO256));
        consume32();

        // Abort at round 30, with a stray block offered mid-run, then a clean rerun
        launch32(abc32, 1'b1, 2'd1);
        repeat (4) @(posedge clk);
        #1;
        b32.in_data  = blk1;
        b32.in_valid = 1'b1;
        #2;
        chk("run_in_ready", 512'(b32.in_ready), 512'd0);
        @(posedge clk);
        #1;
        b32.in_valid = 1'b0;
        chk("run_ignores_valid", 512'(busy32), 512'd1);
        repeat (25) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("abort_out_valid", 512'(b32.out_valid), 512'd0);
        chk("abort_busy", 512'(busy32), 512'd0);
        chk("abort_out_hash", 512'(b32.out_hash), 512'd0);
        chk("abort_in_ready", 512'(b32.in_ready), 512'd1);
        launch32(abc32, 1'b1, 2'd1);
        wait32(lat);
        chk("lat_rerun", 512'(lat), 512'd64);
        chk("hash_rerun", 512'(b32.out_hash), 512'(EXP_ABC256));
        consume32();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
